// File: rtl/simd_mac_seq.sv
// rtl/simd_mac_seq.sv - tile job sequencer for a dual-weight SIMD MAC array
module simd_mac_seq #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int cnt_bw  = 8,
    parameter int lane_bw = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               mode_in,
    input  logic [cnt_bw-1:0]  k_len,
    output logic               act_mode,
    input  logic               w_empty,
    output logic               w_rd,
    output logic               load_en,
    output logic [lane_bw-1:0] w_lane,
    output logic               w_sel,
    output logic               w_both,
    input  logic               act_empty,
    output logic               act_rd,
    output logic               exec_valid,
    input  logic               ofifo_full,
    output logic               ofifo_wr,
    output logic               busy,
    output logic               done,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EXEC  = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int WC_BW = $clog2(2 * row + 1);
    localparam int DC_BW = (row + col > 2) ? $clog2(row + col) : 1;

    localparam logic [WC_BW-1:0] W_LAST_SINGLE = WC_BW'(row - 1);
    localparam logic [WC_BW-1:0] W_LAST_DUAL   = WC_BW'(2 * row - 1);
    localparam logic [DC_BW-1:0] D_LAST        = DC_BW'(row + col - 2);

    state_t             state_q;
    logic [cnt_bw-1:0]  k_len_q;
    logic [cnt_bw-1:0]  kc;
    logic [WC_BW-1:0]   wc;
    logic [DC_BW-1:0]   dc;
    logic [WC_BW-1:0]   w_last;
    logic [cnt_bw-1:0]  k_last;

    assign w_last = act_mode ? W_LAST_DUAL : W_LAST_SINGLE;
    // kc counts completed transfers 0..k_len-1, so k_len = 2^cnt_bw-1 never wraps
    assign k_last = k_len_q - cnt_bw'(1);

    // FIFO strobes: combinational so the pop/push lands in the cycle they are high
    assign w_rd       = (state_q == S_LOAD)  && !w_empty    && !abort;
    assign load_en    = w_rd;
    assign act_rd     = (state_q == S_EXEC)  && !act_empty  && !abort;
    assign exec_valid = act_rd;
    assign ofifo_wr   = (state_q == S_WRITE) && !ofifo_full && !abort;

    assign w_lane = (state_q != S_LOAD) ? '0 :
                    act_mode ? lane_bw'(wc >> 1) : lane_bw'(wc);
    assign w_sel  = (state_q == S_LOAD) && act_mode && wc[0];
    assign w_both = (state_q == S_LOAD) && !act_mode;

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            act_mode <= 1'b0;
            k_len_q  <= '0;
            kc       <= '0;
            wc       <= '0;
            dc       <= '0;
        end else if (abort && (state_q != S_IDLE)) begin
            state_q <= S_IDLE;
            kc      <= '0;
            wc      <= '0;
            dc      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        act_mode <= mode_in;
                        k_len_q  <= k_len;
                        kc       <= '0;
                        wc       <= '0;
                        dc       <= '0;
                        state_q  <= (k_len != '0) ? S_LOAD : S_DONE;
                    end
                end
                S_LOAD: begin
                    if (w_rd) begin
                        if (wc == w_last) begin
                            wc      <= '0;
                            state_q <= S_EXEC;
                        end else begin
                            wc <= wc + WC_BW'(1);
                        end
                    end
                end
                S_EXEC: begin
                    if (act_rd) begin
                        if (kc == k_last) begin
                            kc      <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            kc <= kc + cnt_bw'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // pipeline flush through the row+col-1 deep array skew
                    if (dc == D_LAST) begin
                        dc      <= '0;
                        state_q <= S_WRITE;
                    end else begin
                        dc <= dc + DC_BW'(1);
                    end
                end
                S_WRITE: begin
                    if (ofifo_wr) begin
                        if (kc == k_last) begin
                            kc      <= '0;
                            state_q <= S_DONE;
                        end else begin
                            kc <= kc + cnt_bw'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
